// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR bus responder: FSM state encoding and
// byte-strobe expansion.
package csr_pkg;

  typedef enum logic [0:0] {
    CSR_IDLE = 1'b0,
    CSR_RESP = 1'b1
  } csr_state_e;

  // Widest register supported by the strobe helper, in bytes.
  localparam int unsigned CSR_MAX_BYTES = 64;

  // Expand a byte-enable vector into a per-bit mask (strobe b covers bits 8b+7..8b).
  function automatic logic [CSR_MAX_BYTES*8-1:0] csr_strb_mask(
    input logic [CSR_MAX_BYTES-1:0] strb
  );
    logic [CSR_MAX_BYTES*8-1:0] mask;
    mask = '0;
    for (int b = 0; b < CSR_MAX_BYTES; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/csr_w1c_reg.sv
// Single status register: hardware set pulses OR in, software clears bits with a
// strobed write-1-to-clear; a set on the same edge as a clear wins.
module csr_w1c_reg #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REGISTER_WIDTH-1:0] set_i,
  input  logic                      clr_en_i,
  input  logic [REGISTER_WIDTH-1:0] clr_data_i,
  input  logic [REGISTER_WIDTH-1:0] clr_mask_i,
  output logic [REGISTER_WIDTH-1:0] q_o
);

  logic [REGISTER_WIDTH-1:0] clr_bits;
  logic [REGISTER_WIDTH-1:0] stat_p1;

  assign clr_bits = clr_en_i ? (clr_data_i & clr_mask_i) : '0;

  // Register stage: clear first, then OR the set so the set has priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_p1 <= '0;
    end else begin
      stat_p1 <= (stat_p1 & ~clr_bits) | set_i;
    end
  end

  assign q_o = stat_p1;

endmodule

// File: rtl/csr_bus_responder.sv
// Valid/ready CSR responder: NUM_CTRL byte-strobed read/write control registers
// followed by NUM_STAT W1C status registers, one outstanding request at a time.
module csr_bus_responder
  import csr_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_CTRL       = 4,
  parameter int NUM_STAT       = 4,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic                               req_write_i,
  input  logic [ADDR_WIDTH-1:0]              req_addr_i,
  input  logic [REGISTER_WIDTH-1:0]          req_wdata_i,
  input  logic [REGISTER_WIDTH/8-1:0]        req_wstrb_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [REGISTER_WIDTH-1:0]          rsp_rdata_o,
  output logic                               rsp_error_o,
  output logic [NUM_CTRL*REGISTER_WIDTH-1:0] ctrl_o,
  input  logic [NUM_STAT*REGISTER_WIDTH-1:0] stat_set_i,
  output logic [NUM_STAT*REGISTER_WIDTH-1:0] stat_o
);

  localparam int NUM_REGS = NUM_CTRL + NUM_STAT;

  csr_state_e state_q, state_d;

  logic                      accept;
  logic                      wr_accept;
  logic                      in_range;
  logic [REGISTER_WIDTH-1:0] wmask;
  logic [REGISTER_WIDTH-1:0] rd_value;
  logic [REGISTER_WIDTH-1:0] rsp_rdata_p1;
  logic                      rsp_error_p1;
  logic [REGISTER_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic [REGISTER_WIDTH-1:0] stat_q [NUM_STAT];
  logic [NUM_STAT-1:0]       stat_clr_en;

  assign accept    = req_valid_i && req_ready_o;
  assign in_range  = {1'b0, req_addr_i} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign wr_accept = accept && req_write_i && in_range;
  assign wmask     = REGISTER_WIDTH'(csr_strb_mask(CSR_MAX_BYTES'(req_wstrb_i)));

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CSR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CSR_IDLE: if (accept)      state_d = CSR_RESP;
      CSR_RESP: if (rsp_ready_i) state_d = CSR_IDLE;
      default:                   state_d = CSR_IDLE;
    endcase
  end

  // FSM: outputs; both handshake signals are forced low while reset is held.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        CSR_IDLE: req_ready_o = 1'b1;
        CSR_RESP: rsp_valid_o = 1'b1;
        default:  ;
      endcase
    end
  end

  // Read mux sees register contents before this edge's updates.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (req_addr_i == ADDR_WIDTH'(i)) rd_value = ctrl_q[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (req_addr_i == ADDR_WIDTH'(NUM_CTRL + j)) rd_value = stat_q[j];
    end
  end

  // Response stage: captured at acceptance, held until consumed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_rdata_p1 <= '0;
      rsp_error_p1 <= 1'b0;
    end else if (accept) begin
      rsp_error_p1 <= !in_range;
      rsp_rdata_p1 <= (req_write_i || !in_range) ? '0 : rd_value;
    end
  end

  assign rsp_rdata_o = rsp_rdata_p1;
  assign rsp_error_o = rsp_error_p1;

  // Control register stage: byte-strobed replace.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_accept && req_addr_i == ADDR_WIDTH'(i)) begin
          ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (req_wdata_i & wmask);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl_out
    assign ctrl_o[i*REGISTER_WIDTH +: REGISTER_WIDTH] = ctrl_q[i];
  end

  for (genvar j = 0; j < NUM_STAT; j++) begin : g_stat
    assign stat_clr_en[j] = wr_accept && (req_addr_i == ADDR_WIDTH'(NUM_CTRL + j));

    csr_w1c_reg #(
      .REGISTER_WIDTH(REGISTER_WIDTH)
    ) u_stat (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .set_i      (stat_set_i[j*REGISTER_WIDTH +: REGISTER_WIDTH]),
      .clr_en_i   (stat_clr_en[j]),
      .clr_data_i (req_wdata_i),
      .clr_mask_i (wmask),
      .q_o        (stat_q[j])
    );

    assign stat_o[j*REGISTER_WIDTH +: REGISTER_WIDTH] = stat_q[j];
  end

endmodule

// File: tb/tb_csr_bus_responder.sv
// Directed bench for csr_bus_responder with default parameters.
module tb_csr_bus_responder;

  logic         clk_i;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_write_i;
  logic [3:0]   req_addr_i;
  logic [31:0]  req_wdata_i;
  logic [3:0]   req_wstrb_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [31:0]  rsp_rdata_o;
  logic         rsp_error_o;
  logic [127:0] ctrl_o;
  logic [127:0] stat_set_i;
  logic [127:0] stat_o;

  int n_chk  = 0;
  int n_pass = 0;

  csr_bus_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .ctrl_o      (ctrl_o),
    .stat_set_i  (stat_set_i),
    .stat_o      (stat_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request with rsp_ready_i high; returns the response fields.
  task automatic do_req(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    bit ok;
    ok = 0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (req_ready_o) ok = 1;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    stat_set_i  = '0;
    if (!ok) chk("accept_timeout", 0, 1);
    chk("rsp_valid", {127'b0, rsp_valid_o}, 1);
    rdata = rsp_rdata_o;
    err   = rsp_error_o;
    @(posedge clk_i); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc;

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b1;
    stat_set_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", {127'b0, req_ready_o}, 0);
    chk("rst_rsp_valid", {127'b0, rsp_valid_o}, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_stat", stat_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("idle_ready", {127'b0, req_ready_o}, 1);

    // Full write then read of ctrl0
    do_req(1, 4'd0, 32'hDEADBEEF, 4'hF, rd, er);
    chk("wr0_rdata", rd, 0);
    chk("wr0_err", er, 0);
    chk("ctrl0_full", ctrl_o[31:0], 32'hDEADBEEF);
    do_req(0, 4'd0, 0, 0, rd, er);
    chk("rd0_rdata", rd, 32'hDEADBEEF);
    chk("rd0_err", er, 0);

    // Partial strobe write
    do_req(1, 4'd0, 32'h11223344, 4'h5, rd, er);
    do_req(0, 4'd0, 0, 0, rd, er);
    chk("rd0_strb5", rd, 32'hDE22BE44);
    do_req(1, 4'd1, 32'hA5A5A5A5, 4'hF, rd, er);
    chk("ctrl_vec", ctrl_o, {64'h0, 32'hA5A5A5A5, 32'hDE22BE44});

    // Status set / W1C
    stat_set_i[31:0] = 32'h11;
    @(posedge clk_i); #1;
    stat_set_i = '0;
    do_req(0, 4'd4, 0, 0, rd, er);
    chk("stat0_rd", rd, 32'h11);
    do_req(1, 4'd4, 32'h01, 4'h1, rd, er);
    chk("stat0_clr0", stat_o[31:0], 32'h10);
    stat_set_i[4] = 1'b1;
    do_req(1, 4'd4, 32'h10, 4'h1, rd, er);
    chk("stat0_set_wins", stat_o[31:0], 32'h10);
    do_req(1, 4'd4, 32'h10, 4'h0, rd, er);
    chk("stat0_strb0", stat_o[31:0], 32'h10);
    chk("strb0_err", er, 0);
    do_req(1, 4'd4, 32'h10, 4'h1, rd, er);
    chk("stat0_clr4", stat_o[31:0], 32'h0);
    stat_set_i[63] = 1'b1;
    @(posedge clk_i); #1;
    stat_set_i = '0;
    do_req(0, 4'd5, 0, 0, rd, er);
    chk("stat1_rd", rd, 32'h80000000);

    // Out-of-range accesses
    do_req(0, 4'd9, 0, 0, rd, er);
    chk("oor_rd_err", er, 1);
    chk("oor_rd_data", rd, 0);
    do_req(1, 4'd15, 32'hFFFFFFFF, 4'hF, rd, er);
    chk("oor_wr_err", er, 1);
    chk("oor_ctrl", ctrl_o, {64'h0, 32'hA5A5A5A5, 32'hDE22BE44});
    chk("oor_stat", stat_o, {64'h0, 32'h80000000, 32'h0});
    do_req(0, 4'd7, 0, 0, rd, er);
    chk("last_stat_err", er, 0);

    // Backpressure
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 4'd0;
    @(posedge clk_i); #1;
    req_addr_i = 4'd1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {127'b0, rsp_valid_o}, 1);
      chk("bp_rdata", rsp_rdata_o, 32'hDE22BE44);
      chk("bp_ready", {127'b0, req_ready_o}, 0);
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_release_ready", {127'b0, req_ready_o}, 1);
    chk("bp_release_valid", {127'b0, rsp_valid_o}, 0);

    // Back-to-back throughput
    acc = 0;
    req_valid_i = 1'b1;
    req_addr_i  = 4'd1;
    for (int k = 0; k < 8; k++) begin
      if (req_ready_o) acc++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_rdata", rsp_rdata_o, 32'hA5A5A5A5);
    @(posedge clk_i); #1;

    // Reset while a response is pending
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 4'd0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("pre_rst_valid", {127'b0, rsp_valid_o}, 1);
    rst_ni = 1'b0;
    stat_set_i = '1;
    @(posedge clk_i); #1;
    chk("rst_resp_valid", {127'b0, rsp_valid_o}, 0);
    chk("rst_resp_ctrl", ctrl_o, 0);
    chk("rst_resp_stat", stat_o, 0);
    chk("rst_resp_rdata", rsp_rdata_o, 0);
    stat_set_i = '0;
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    #1;
    chk("post_rst_ready", {127'b0, req_ready_o}, 1);
    chk("post_rst_valid", {127'b0, rsp_valid_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
